// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode values, legality
// check and the skid-buffer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_XNOR = 4'b1011;

    // Occupancy of the two-entry buffer (main register, skid register).
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    // True for opcodes the ALU fully decodes; anything else would leave
    // the ALU result bus undriven.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_XNOR: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_entry.sv
// One buffered ALU operation {op, a, b, tag}; loads when 'load' is high,
// otherwise holds. Clears to zero on asynchronous reset.
module alu_issue_entry #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [3:0]       nxt_op,
    input  logic [31:0]      nxt_a,
    input  logic [31:0]      nxt_b,
    input  logic [TAG_W-1:0] nxt_tag,
    output logic [3:0]       op,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [TAG_W-1:0] tag
);

    // Capture a new operation on load, hold it otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op  <= '0;
            a   <= '0;
            b   <= '0;
            tag <= '0;
        end else if (load) begin
            op  <= nxt_op;
            a   <= nxt_a;
            b   <= nxt_b;
            tag <= nxt_tag;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the 32-bit ALU. Two-entry skid buffer
// (main drives the ALU, skid absorbs one extra op) with illegal-opcode drop.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and ready here is a function of
// buffer state only, so no combinational path runs from out_ready to in_ready.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic             s3,
    output logic             s2,
    output logic             s1,
    output logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal_op,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [1:0]       dbg_state
);

    buf_state_t state, state_nxt;

    logic             accept, legal_accept, drain;
    logic             main_load, main_from_skid, skid_load;
    logic [3:0]       main_op, skid_op, main_nxt_op;
    logic [31:0]      main_a, main_b, skid_a, skid_b, main_nxt_a, main_nxt_b;
    logic [TAG_W-1:0] main_tag, skid_tag, main_nxt_tag;

    assign in_ready     = (state != ST_FULL);
    assign out_valid    = (state != ST_EMPTY);
    assign accept       = in_valid && in_ready;
    assign legal_accept = accept && op_is_legal(in_op);
    assign drain        = out_valid && out_ready;
    assign dbg_state    = state;

    // Buffer occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Next occupancy and which register loads from where; an illegal
    // accept behaves exactly like no accept.
    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (legal_accept) begin
                    state_nxt = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (legal_accept && drain) begin
                    main_load = 1'b1;
                end else if (legal_accept) begin
                    state_nxt = ST_FULL;
                    skid_load = 1'b1;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    state_nxt      = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    assign main_nxt_op  = main_from_skid ? skid_op  : in_op;
    assign main_nxt_a   = main_from_skid ? skid_a   : in_a;
    assign main_nxt_b   = main_from_skid ? skid_b   : in_b;
    assign main_nxt_tag = main_from_skid ? skid_tag : in_tag;

    alu_issue_entry #(.TAG_W(TAG_W)) u_main (
        .clk(clk), .rst(rst), .load(main_load),
        .nxt_op(main_nxt_op), .nxt_a(main_nxt_a), .nxt_b(main_nxt_b), .nxt_tag(main_nxt_tag),
        .op(main_op), .a(main_a), .b(main_b), .tag(main_tag)
    );

    alu_issue_entry #(.TAG_W(TAG_W)) u_skid (
        .clk(clk), .rst(rst), .load(skid_load),
        .nxt_op(in_op), .nxt_a(in_a), .nxt_b(in_b), .nxt_tag(in_tag),
        .op(skid_op), .a(skid_a), .b(skid_b), .tag(skid_tag)
    );

    assign a                = main_a;
    assign b                = main_b;
    assign {s3, s2, s1, s0} = main_op;
    assign out_tag          = main_tag;

    // Sticky flag for any accepted illegal opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               illegal_op <= 1'b0;
        else if (accept && !op_is_legal(in_op)) illegal_op <= 1'b1;
    end

    // Count completed output handshakes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        issued_cnt <= '0;
        else if (drain) issued_cnt <= issued_cnt + 1'b1;
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed steps plus random streaming,
// checked against a queue-based model of a two-deep FIFO in front of an ALU.
module tb_alu_issue_stage;

    localparam int TAG_W = 5;
    localparam int W     = 4 + 32 + 32 + TAG_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready;
    logic [3:0]       in_op;
    logic [31:0]      in_a, in_b, a, b;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             s3, s2, s1, s0, illegal_op;
    logic [15:0]      issued_cnt;
    logic [1:0]       dbg_state;

    // Narrow-counter copy, fed identically, to observe counter wrap.
    logic             in_ready4, out_valid4, illegal_op4;
    logic [31:0]      a4, b4;
    logic [TAG_W-1:0] out_tag4;
    logic             s3_4, s2_4, s1_4, s0_4;
    logic [3:0]       issued_cnt4;
    logic [1:0]       dbg_state4;

    alu_issue_stage #(.TAG_W(TAG_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .a(a), .b(b), .s3(s3), .s2(s2), .s1(s1), .s0(s0),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .illegal_op(illegal_op), .issued_cnt(issued_cnt), .dbg_state(dbg_state)
    );

    alu_issue_stage #(.TAG_W(TAG_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .a(a4), .b(b4), .s3(s3_4), .s2(s2_4), .s1(s1_4), .s0(s0_4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_tag(out_tag4),
        .illegal_op(illegal_op4), .issued_cnt(issued_cnt4), .dbg_state(dbg_state4)
    );

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_illegal;
    int unsigned  exp_cnt;
    int           checks   = 0;
    int           failures = 0;
    logic [3:0]   legal_ops [6] = '{4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

    // What the ALU produces for a given select code.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            4'b0000: return x + y;
            4'b0001: return x - y;
            4'b1000: return x & y;
            4'b1001: return x | y;
            4'b1010: return x ^ y;
            4'b1011: return ~(x ^ y);
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the presented state, then advance one edge updating the model.
    // Entered and left at 1 time unit after a rising edge.
    task automatic cycle();
        logic [W-1:0] front;
        logic         hs_in, hs_out;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
        chk("out_valid4", 32'(out_valid4), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            front = exp_q[0];
            chk("op",    32'({s3, s2, s1, s0}), 32'(front[W-1 -: 4]));
            chk("a",     a,                     front[W-5 -: 32]);
            chk("b",     b,                     front[W-37 -: 32]);
            chk("tag",   32'(out_tag),          32'(front[TAG_W-1:0]));
            chk("alu_c", alu_ref({s3, s2, s1, s0}, a, b),
                alu_ref(front[W-1 -: 4], front[W-5 -: 32], front[W-37 -: 32]));
        end
        hs_out = (exp_q.size() != 0) && out_ready;
        hs_in  = in_valid && (exp_q.size() < 2);
        @(posedge clk);
        if (hs_out) begin
            void'(exp_q.pop_front());
            exp_cnt++;
        end
        if (hs_in) begin
            if (in_op inside {4'b0000, 4'b0001, 4'b1000, 4'b1001, 4'b1010, 4'b1011})
                exp_q.push_back({in_op, in_a, in_b, in_tag});
            else
                exp_illegal = 1'b1;
        end
        #1;
        chk("illegal_op",  32'(illegal_op),  32'(exp_illegal));
        chk("issued_cnt",  32'(issued_cnt),  exp_cnt % 65536);
        chk("issued_cnt4", 32'(issued_cnt4), exp_cnt % 16);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAG_W-1:0] t);
        in_valid = v;
        in_op    = op;
        in_a     = x;
        in_b     = y;
        in_tag   = t;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        exp_illegal = 1'b0;
        exp_cnt     = 0;
        rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [3:0] rop;
        logic       seen17;
        seen17    = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        rst = 1'b1;
        #1;
        chk("rst_out_valid",  32'(out_valid),      32'd0);
        chk("rst_in_ready",   32'(in_ready),       32'd1);
        chk("rst_a",          a,                   32'd0);
        chk("rst_b",          b,                   32'd0);
        chk("rst_sel",        32'({s3, s2, s1, s0}), 32'd0);
        chk("rst_tag",        32'(out_tag),        32'd0);
        chk("rst_illegal",    32'(illegal_op),     32'd0);
        chk("rst_cnt",        32'(issued_cnt),     32'd0);
        do_reset();

        // Single ADD presented the cycle after acceptance.
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 32'd5, 32'd7, 5'd3);
        cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_c",     alu_ref({s3, s2, s1, s0}, a, b), 32'd12);
        chk("add_tag",   32'(out_tag), 32'd3);
        cycle();
        chk("add_cnt",   32'(issued_cnt), 32'd1);

        // Backpressure: two accepted, third refused until a drain.
        out_ready = 1'b0;
        drive(1'b1, 4'b0001, 32'd10, 32'd4, 5'd1);
        cycle();
        drive(1'b1, 4'b1000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd2);
        cycle();
        drive(1'b1, 4'b1001, 32'h1200_0003, 32'h0034_0500, 5'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle();
        out_ready = 1'b1;
        chk("sub_c", alu_ref({s3, s2, s1, s0}, a, b), 32'd6);
        cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        for (int i = 0; i < 4; i++) cycle();

        // Illegal opcode: consumed, flagged, never presented or counted.
        drive(1'b1, 4'b0101, 32'd1, 32'd2, 5'd9);
        cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        chk("illegal_set",  32'(illegal_op), 32'd1);
        chk("illegal_nov",  32'(out_valid),  32'd0);
        cycle();
        chk("illegal_hold", 32'(illegal_op), 32'd1);

        // Random streaming of legal ops at full rate.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rop = legal_ops[$urandom_range(0, 5)];
            drive(1'b1, rop, $urandom, $urandom, TAG_W'($urandom_range(0, 31)));
            cycle();
            if (exp_cnt == 17 && !seen17) begin
                seen17 = 1'b1;
                chk("wrap_cnt4", 32'(issued_cnt4), 32'd1);
            end
        end
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        for (int i = 0; i < 3; i++) cycle();
        chk("stream_cnt", 32'(issued_cnt), 32'd100);

        // Reset while FULL discards both entries at once.
        out_ready = 1'b0;
        drive(1'b1, 4'b1010, 32'hAAAA_0000, 32'h0000_5555, 5'd7);
        cycle();
        drive(1'b1, 4'b1011, 32'h1234_5678, 32'h8765_4321, 5'd8);
        cycle();
        drive(1'b0, 4'b0000, 32'd0, 32'd0, '0);
        chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_cnt",       32'(issued_cnt), 32'd0);
        exp_q.delete();
        exp_illegal = 1'b0;
        exp_cnt     = 0;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("post_rst_cnt", 32'(issued_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
